// File: rtl/trigger_capture_pkg.sv
// Shared types and helpers for the post-trigger capture buffer.
package trigger_capture_pkg;

  // Capture controller states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_READ  = 3'd4
  } state_e;

  // Address width needed to index a buffer of the given depth.
  function automatic int unsigned addr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/tc_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
// No reset on the storage or the read register so it maps onto block RAM.
module tc_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int AW     = 8
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Write port: store one sample per enabled cycle.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  // Read port: one-cycle registered read on request.
  always_ff @(posedge i_clk) begin
    if (i_re) begin
      rdata_q <= mem_q[i_raddr];
    end
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/trigger_capture.sv
// Post-trigger capture buffer: rolling pre-trigger history, fixed post-trigger
// window after the trigger, then a frozen snapshot read out oldest-first.
module trigger_capture
  import trigger_capture_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 256,
  parameter int PRE_TRIG = 64
) (
  input  logic              i_clk,
  input  logic              i_arst,
  input  logic              i_arm,
  input  logic              i_trig,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_rd_en,
  output logic              o_armed,
  output logic              o_done,
  output logic              o_rd_valid,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_last
);

  localparam int AW = addr_width(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] PRE_CNT  = CW'(PRE_TRIG);
  localparam logic [CW-1:0] POST_CNT = CW'(DEPTH - PRE_TRIG);
  localparam logic [CW-1:0] LAST_RD  = CW'(DEPTH - 1);
  localparam logic [AW-1:0] PRE_OFS  = AW'(PRE_TRIG);

  state_e            state_q;
  logic [AW-1:0]     wp_q;
  logic [AW-1:0]     rp_q;
  logic [AW-1:0]     sa_q;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     rcnt_q;
  logic              armed_q;
  logic              done_q;
  logic              rd_valid_q;
  logic              rd_last_q;

  logic              capturing_s;
  logic              we_s;
  logic              rd_acc_s;
  logic              trig_hit_s;
  logic [CW-1:0]     cnt_inc_s;
  logic [DATA_W-1:0] ram_rdata_s;

  // Decode write/read strobes and the trigger event from the current state.
  always_comb begin
    capturing_s = (state_q == ST_PRE) || (state_q == ST_ARMED) || (state_q == ST_POST);
    we_s        = capturing_s && i_valid;
    rd_acc_s    = (state_q == ST_READ) && i_rd_en;
    trig_hit_s  = (state_q == ST_ARMED) && i_valid && i_trig;
    cnt_inc_s   = cnt_q + CW'(1);
  end

  // Capture controller: state, pointers, counters and registered status.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q    <= ST_IDLE;
      wp_q       <= '0;
      rp_q       <= '0;
      sa_q       <= '0;
      cnt_q      <= '0;
      rcnt_q     <= '0;
      armed_q    <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc_s;
      rd_last_q  <= rd_acc_s && (rcnt_q == LAST_RD);
      if (we_s) begin
        wp_q <= wp_q + AW'(1);
      end
      case (state_q)
        ST_IDLE: begin
          if (i_arm) begin
            state_q <= ST_PRE;
            wp_q    <= '0;
            cnt_q   <= '0;
            armed_q <= 1'b1;
          end
        end
        ST_PRE: begin
          // Trigger is ignored here so the history is always complete.
          if (i_valid) begin
            cnt_q <= cnt_inc_s;
            if (cnt_inc_s == PRE_CNT) begin
              state_q <= ST_ARMED;
            end
          end
        end
        ST_ARMED: begin
          if (trig_hit_s) begin
            sa_q    <= wp_q - PRE_OFS;
            cnt_q   <= CW'(1);
            armed_q <= 1'b0;
            // A one-sample post window is completed by the trigger itself.
            if (POST_CNT == CW'(1)) begin
              state_q <= ST_READ;
              rp_q    <= wp_q - PRE_OFS;
              rcnt_q  <= '0;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_POST;
            end
          end
        end
        ST_POST: begin
          if (i_valid) begin
            cnt_q <= cnt_inc_s;
            if (cnt_inc_s == POST_CNT) begin
              state_q <= ST_READ;
              rp_q    <= sa_q;
              rcnt_q  <= '0;
              done_q  <= 1'b1;
            end
          end
        end
        ST_READ: begin
          if (i_rd_en) begin
            rp_q   <= rp_q + AW'(1);
            rcnt_q <= rcnt_q + CW'(1);
            // done drops in the same cycle the last sample is presented.
            if (rcnt_q == LAST_RD) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          armed_q <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  tc_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (we_s),
    .i_waddr (wp_q),
    .i_wdata (i_data),
    .i_re    (rd_acc_s),
    .i_raddr (rp_q),
    .o_rdata (ram_rdata_s)
  );

  assign o_armed    = armed_q;
  assign o_done     = done_q;
  assign o_rd_valid = rd_valid_q;
  assign o_rd_last  = rd_last_q;
  // The RAM read register has no reset, so data is qualified by the valid flag.
  assign o_rd_data  = rd_valid_q ? ram_rdata_s : '0;

endmodule

// File: tb/tb_trigger_capture.sv
// Randomised bench for trigger_capture against a sample-list reference model.
module tb_trigger_capture;

  localparam int DW = 8;
  localparam int DP = 16;
  localparam int PT = 4;

  localparam int M_IDLE    = 0;
  localparam int M_CAPTURE = 1;
  localparam int M_POST    = 2;
  localparam int M_READ    = 3;

  logic          i_clk = 1'b0;
  logic          i_arst = 1'b0;
  logic          i_arm = 1'b0;
  logic          i_trig = 1'b0;
  logic          i_valid = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic          i_rd_en = 1'b0;
  logic          o_armed;
  logic          o_done;
  logic          o_rd_valid;
  logic [DW-1:0] o_rd_data;
  logic          o_rd_last;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: every accepted sample since arm, plus trigger position.
  int            m_phase = M_IDLE;
  int            trig_idx = -1;
  int            ridx = 0;
  logic [DW-1:0] samples[$];
  logic          exp_rd_valid = 1'b0;
  logic          exp_rd_last = 1'b0;
  logic [DW-1:0] exp_rd_data = '0;

  int            reads_seen = 0;
  logic [DW-1:0] got[$];
  logic [DW-1:0] ramp = '0;
  bit            trig_lvl = 1'b0;

  always #5 i_clk = ~i_clk;

  trigger_capture #(
    .DATA_W   (DW),
    .DEPTH    (DP),
    .PRE_TRIG (PT)
  ) dut (
    .i_clk      (i_clk),
    .i_arst     (i_arst),
    .i_arm      (i_arm),
    .i_trig     (i_trig),
    .i_valid    (i_valid),
    .i_data     (i_data),
    .i_rd_en    (i_rd_en),
    .o_armed    (o_armed),
    .o_done     (o_done),
    .o_rd_valid (o_rd_valid),
    .o_rd_data  (o_rd_data),
    .o_rd_last  (o_rd_last)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, expv, $time);
    end
  endtask

  function automatic logic [31:0] got_at(input int i);
    if (i < got.size()) return 32'(got[i]);
    return 32'hDEAD_BEEF;
  endfunction

  // Apply one clock edge of the capture rules to the model.
  task automatic model_edge(input bit arm, input bit v, input logic [DW-1:0] d,
                            input bit trg, input bit rd);
    exp_rd_valid = 1'b0;
    exp_rd_last  = 1'b0;
    case (m_phase)
      M_IDLE: begin
        if (arm) begin
          m_phase  = M_CAPTURE;
          trig_idx = -1;
          samples.delete();
        end
      end
      M_CAPTURE, M_POST: begin
        if (v) begin
          if (m_phase == M_CAPTURE && samples.size() >= PT && trg) begin
            trig_idx = samples.size();
            m_phase  = M_POST;
          end
          samples.push_back(d);
          if (m_phase == M_POST && samples.size() == trig_idx + DP - PT) begin
            m_phase = M_READ;
            ridx    = 0;
          end
        end
      end
      M_READ: begin
        if (rd) begin
          exp_rd_valid = 1'b1;
          exp_rd_data  = samples[trig_idx - PT + ridx];
          exp_rd_last  = (ridx == DP - 1);
          ridx++;
          if (ridx == DP) m_phase = M_IDLE;
        end
      end
      default: m_phase = M_IDLE;
    endcase
  endtask

  task automatic compare_outputs();
    check_val("armed", 32'(o_armed), 32'(m_phase == M_CAPTURE));
    check_val("done", 32'(o_done), 32'(m_phase == M_READ));
    check_val("rd_valid", 32'(o_rd_valid), 32'(exp_rd_valid));
    check_val("rd_last", 32'(o_rd_last), 32'(exp_rd_last));
    if (exp_rd_valid) check_val("rd_data", 32'(o_rd_data), 32'(exp_rd_data));
    if (o_rd_valid === 1'b1) begin
      reads_seen++;
      got.push_back(o_rd_data);
    end
  endtask

  // Compare the previous edge's outputs, then drive the next edge.
  task automatic cycle(input bit arm, input bit v, input bit trg, input bit rd);
    @(negedge i_clk);
    compare_outputs();
    i_arm   = arm;
    i_valid = v;
    i_trig  = trg;
    i_rd_en = rd;
    i_data  = ramp;
    model_edge(arm, v, ramp, trg, rd);
    if (v) ramp++;
  endtask

  task automatic do_reset(input int n);
    @(negedge i_clk);
    compare_outputs();
    i_arst       = 1'b1;
    m_phase      = M_IDLE;
    exp_rd_valid = 1'b0;
    exp_rd_last  = 1'b0;
    for (int k = 0; k < n; k++) begin
      i_arm   = 1'($urandom);
      i_valid = 1'($urandom);
      i_trig  = 1'($urandom);
      i_rd_en = 1'($urandom);
      i_data  = DW'($urandom);
      @(negedge i_clk);
      compare_outputs();
      check_val("rst_data", 32'(o_rd_data), 32'd0);
    end
    i_arst  = 1'b0;
    i_arm   = 1'b0;
    i_valid = 1'b0;
    i_trig  = 1'b0;
    i_rd_en = 1'b0;
  endtask

  task automatic run_capture(input int trig_after, input int valid_pct, input bit early,
                             input bit gap_rise, input int rd_pct, input bit noise,
                             input bit abort_post);
    int guard;
    bit v, a, r;
    ramp = '0;
    reads_seen = 0;
    got.delete();
    trig_lvl = early;
    cycle(1'b1, 1'b0, trig_lvl, 1'b0);
    guard = 0;
    while ((m_phase == M_CAPTURE || m_phase == M_POST) && guard < 1000) begin
      v = ($urandom_range(0, 99) < valid_pct);
      if (!trig_lvl && int'(ramp) >= trig_after && !(gap_rise && v)) trig_lvl = 1'b1;
      a = noise && ($urandom_range(0, 3) == 0);
      r = noise && ($urandom_range(0, 1) == 0);
      cycle(a, v, trig_lvl, r);
      if (abort_post && m_phase == M_POST && samples.size() - trig_idx >= 5) begin
        do_reset(3);
        return;
      end
      guard++;
    end
    guard = 0;
    while (m_phase == M_READ && guard < 400) begin
      r = ($urandom_range(0, 99) < rd_pct);
      a = noise && ($urandom_range(0, 2) == 0);
      v = 1'($urandom);
      cycle(a, v, trig_lvl, r);
      guard++;
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check_val("rd_count", 32'(reads_seen), 32'(DP));
  endtask

  initial begin
    #1 i_arst = 1'b1;
    do_reset(4);

    // Basic capture: trigger at sample 30.
    run_capture(30, 100, 1'b0, 1'b0, 100, 1'b0, 1'b0);
    check_val("basic_first", got_at(0), 32'd26);
    check_val("basic_trig", got_at(PT), 32'd30);
    check_val("basic_last", got_at(DP - 1), 32'd41);

    // Early trigger: already high at arm.
    run_capture(0, 100, 1'b1, 1'b0, 100, 1'b0, 1'b0);
    check_val("early_first", got_at(0), 32'd0);
    check_val("early_trig", got_at(PT), 32'd4);
    check_val("early_last", got_at(DP - 1), 32'd15);

    // Gapped valid, trigger rising while valid is low.
    run_capture(20, 50, 1'b0, 1'b1, 100, 1'b0, 1'b0);
    for (int i = 1; i < DP; i++) begin
      check_val("gap_consec", got_at(i), 32'(got_at(0) + 32'(i)));
    end

    // Ignored controls and irregular read stalls.
    run_capture(25, 100, 1'b0, 1'b0, 60, 1'b1, 1'b0);

    // Reset in the middle of the post window, then a full capture.
    run_capture(12, 100, 1'b0, 1'b0, 100, 1'b0, 1'b1);
    run_capture(30, 100, 1'b0, 1'b0, 100, 1'b0, 1'b0);
    check_val("rearm_trig", got_at(PT), 32'd30);

    // Randomised captures.
    for (int n = 0; n < 8; n++) begin
      run_capture($urandom_range(0, 60), $urandom_range(30, 100), 1'($urandom),
                  1'b0, $urandom_range(30, 100), 1'($urandom), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/trigger_capture.md
# trigger_capture

Post-trigger capture buffer that consumes the level trigger produced by the on-chip Signal Tap trigger counter. Once armed, it keeps a rolling pre-trigger history of a sample stream. When the trigger goes high it records a fixed post-trigger window, then freezes. The frozen window is read out oldest-first through a one-sample-per-request handshake, which gives DCSK debug a deterministic snapshot around the trigger instant.

## Interface
- DATA_W, 16, sample width in bits
- DEPTH, 256, total samples in one capture; power of two, ≥ 4
- PRE_TRIG, 64, samples kept before the trigger sample; 1 ≤ PRE_TRIG ≤ DEPTH-1
- i_clk  in  1  single clock; all logic is on its rising edge
- i_arst  in  1  reset, asynchronous and active-high
- i_arm  in  1  one-cycle pulse that starts a capture; honoured only in IDLE
- i_trig  in  1  trigger level; sampled only in ARMED, stays high once asserted
- i_valid  in  1  qualifies i_data for this cycle
- i_data  in  DATA_W  sample stream
- i_rd_en  in  1  requests the next stored sample; honoured only in READ
- o_armed  out  1  high in PRE and ARMED
- o_done  out  1  high in READ; capture frozen and readable
- o_rd_valid  out  1  o_rd_data is valid this cycle
- o_rd_data  out  DATA_W  read sample
- o_rd_last  out  1  marks the DEPTH-th (final) read sample, coincident with o_rd_valid

## Operation
- States: IDLE, PRE, ARMED, POST, READ.
- IDLE → PRE on i_arm. Clear the write pointer wp and the sample counter cnt.
- In PRE, ARMED and POST, every cycle with i_valid writes i_data to RAM[wp], then wp increments modulo DEPTH (wrap-around by natural overflow).
- PRE: cnt counts valid samples. Go to ARMED after the write that makes cnt = PRE_TRIG. i_trig is ignored in PRE, so the pre-trigger history is always complete.
- ARMED: history keeps overwriting the ring. The trigger sample is the first valid sample in ARMED with i_trig = 1.
  - On that cycle, latch the start address sa = wp − PRE_TRIG (mod DEPTH), write the sample, set cnt = 1 and go to POST.
  - If i_trig is high with i_valid low, stay in ARMED until the next valid sample.
- POST: count valid samples. Go to READ after the write that makes cnt = DEPTH − PRE_TRIG, where the trigger sample counts as 1.
- READ: writes stop. The read pointer starts at sa. Each i_rd_en reads RAM[rp], then rp increments modulo DEPTH and the read counter increments.
- After the DEPTH-th accepted i_rd_en, go to IDLE. o_done drops in the same cycle that o_rd_last is presented.
- i_rd_en outside READ has no effect. i_arm outside IDLE is ignored; a capture cannot be restarted mid-flight.
- Simultaneous i_arm and i_trig in IDLE: arm only; the trigger is evaluated from ARMED onward.
- Reset mid-operation: every state returns to IDLE at once. RAM contents are don't-care; pointers and counters are cleared.
- Counters are $clog2(DEPTH)+1 bits wide so that DEPTH itself is representable.

## Timing
- Reset values: o_armed = 0, o_done = 0, o_rd_valid = 0, o_rd_last = 0, o_rd_data = 0; state = IDLE.
- o_armed rises in the cycle after the i_arm pulse.
- o_done rises in the cycle after the final POST write.
- Read latency is 1 cycle: i_rd_en in cycle n gives o_rd_valid and o_rd_data in cycle n+1 from a registered RAM output.
- Back-to-back i_rd_en gives one sample per cycle.
- Read order is fixed: index 0 is the oldest pre-trigger sample, index PRE_TRIG is the trigger sample, and index DEPTH−1 is the last post-trigger sample.
- Minimum time from i_arm to o_done is DEPTH valid samples plus 1 cycle.

## Structure
- Package trigger_capture_pkg holds:
  - the state enum (IDLE, PRE, ARMED, POST, READ);
  - an address-width function, clog2 of DEPTH.
- Sub-module tc_ram: simple dual-port RAM, DEPTH × DATA_W, with one write port and one registered read port. It must infer block RAM.
- The top level holds the FSM, wp, rp, sa, the counters and the output registers.

## Test plan
All scenarios use DATA_W=8, DEPTH=16, PRE_TRIG=4, and i_data is a ramp 0,1,2,… valid every cycle.
- Reset: assert i_arst while toggling all inputs → all outputs 0 and no write occurs. Release → IDLE.
- Basic capture:
  - arm at sample 0, raise i_trig at sample 30, drain with continuous i_rd_en;
  - expect reads 26..41;
  - trigger value 30 at read index 4;
  - o_rd_last with 41;
  - o_done low on the next cycle.
- Early trigger:
  - i_trig already high when i_arm arrives;
  - expect the trigger sample to be sample 4;
  - expect reads 0..15.
- Gapped valid:
  - i_valid 50% duty cycle, i_trig rises while i_valid = 0;
  - expect the trigger sample to be the next valid value;
  - expect exactly 16 consecutive valid values read back.
- Ignored controls:
  - i_arm pulses during POST and READ have no effect;
  - i_rd_en during ARMED and POST produces no o_rd_valid;
  - read stall: i_rd_en toggled irregularly still gives the correct order with 1-cycle latency.
- Reset mid-POST: assert i_arst after 5 post samples → IDLE, o_done never rises. Re-arm → a full correct capture follows.
